// File: rtl/stim_pkg.sv
// stim_pkg: shared FSM state type and sweep direction encodings for pattern_stim_gen
package stim_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/bin2gray.sv
// bin2gray: combinational binary to reflected Gray code conversion
module bin2gray #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);
  assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/pattern_stim_gen.sv
// pattern_stim_gen: exhaustive WIDTH-bit up/down sweep, each value held HOLD cycles; Gray output when STIM_GRAY_EN is defined
module pattern_stim_gen
  import stim_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int HOLD  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             pause,
`ifdef STIM_GRAY_EN
  input  logic             gray_sel,
`endif
  output logic [WIDTH-1:0] pattern,
  output logic             valid,
  output logic             busy,
  output logic             done
);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [WIDTH-1:0] ONES = '1;
  state_t           state_q;
  logic [WIDTH-1:0] cnt_q, cnt_d, pat_d;
  logic [HW-1:0]    hold_q;
  logic             dir_q, last_hold, at_term;
  // next count: start value while idle, otherwise one step in the latched direction
  always_comb begin
    cnt_d     = (state_q == IDLE) ? ((dir == DIR_DOWN) ? ONES : '0)
                                  : ((dir_q == DIR_DOWN) ? cnt_q - 1'b1 : cnt_q + 1'b1);
    at_term   = cnt_q == ((dir_q == DIR_UP) ? ONES : '0);
    last_hold = hold_q == HOLD_LAST;
  end
`ifdef STIM_GRAY_EN
  logic             gray_q, gray_d;
  logic [WIDTH-1:0] gray_cnt;
  assign gray_d = (state_q == IDLE) ? gray_sel : gray_q;
  assign pat_d  = gray_d ? gray_cnt : cnt_d;
  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (.bin_i(cnt_d), .gray_o(gray_cnt));
  // Gray select is captured only when a sweep is launched
  always_ff @(posedge clk) begin
    if (rst) gray_q <= 1'b0;
    else if (state_q == IDLE && start) gray_q <= gray_sel;
  end
`else
  assign pat_d = cnt_d;
`endif
  // sweep FSM with registered outputs; the terminal check precedes the step so count never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      dir_q   <= DIR_UP;
      pattern <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          cnt_q   <= cnt_d;
          hold_q  <= '0;
          dir_q   <= dir;
          pattern <= pat_d;
          valid   <= 1'b1;
          busy    <= 1'b1;
        end
        RUN: if (!pause) begin
          if (!last_hold) hold_q <= hold_q + 1'b1;
          else if (at_term) begin
            state_q <= DONE;
            valid   <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt_q   <= cnt_d;
            hold_q  <= '0;
            pattern <= pat_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_stim_gen.sv
// tb_pattern_stim_gen: table vectors, corner sequences and randomized sweeps checked against a behavioural sweep model
module tb_pattern_stim_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic a_start = 0, a_dir = 0, a_pause = 0, a_gs = 0;
  logic [2:0] a_pat;
  logic a_valid, a_busy, a_done;
  logic b_start = 0, b_dir = 0, b_pause = 0;
  logic [1:0] b_pat;
  logic b_valid, b_busy, b_done;
  logic c_start = 0, c_dir = 1, c_pause = 0;
  logic [5:0] c_pat;
  logic c_valid, c_busy, c_done;
  int n_chk = 0, n_fail = 0;
  pattern_stim_gen #(.WIDTH(3), .HOLD(2)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .dir(a_dir), .pause(a_pause),
`ifdef STIM_GRAY_EN
    .gray_sel(a_gs),
`endif
    .pattern(a_pat), .valid(a_valid), .busy(a_busy), .done(a_done));
  pattern_stim_gen #(.WIDTH(2), .HOLD(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .dir(b_dir), .pause(b_pause),
`ifdef STIM_GRAY_EN
    .gray_sel(1'b0),
`endif
    .pattern(b_pat), .valid(b_valid), .busy(b_busy), .done(b_done));
  pattern_stim_gen u_c (
    .clk(clk), .rst(rst), .start(c_start), .dir(c_dir), .pause(c_pause),
`ifdef STIM_GRAY_EN
    .gray_sel(1'b0),
`endif
    .pattern(c_pat), .valid(c_valid), .busy(c_busy), .done(c_done));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model of DUT a (WIDTH 3, HOLD 2): position m_p walks a flat list of 8*2 presentation slots then one done slot
  bit m_act = 0, m_dir = 0, m_g = 0;
  int m_p = 0, m_pat = 0;
  localparam int SLOTS = 16;
  function automatic int enc(input int v, input bit g);
    return g ? (v ^ (v >> 1)) : v;
  endfunction
  task automatic a_step();
    if (rst) begin
      m_act = 0;
      m_pat = 0;
    end else if (!m_act) begin
      if (a_start) begin
        m_act = 1; m_p = 0; m_dir = a_dir; m_g = a_gs;
      end
    end else if (m_p == SLOTS) m_act = 0;
    else if (!a_pause) m_p++;
    if (m_act && m_p < SLOTS) m_pat = enc(m_dir ? 7 - m_p / 2 : m_p / 2, m_g);
  endtask
  task automatic tick();
    @(posedge clk);
    a_step();
    #1;
    chk("a_pattern", a_pat, m_pat);
    chk("a_valid", a_valid, m_act && m_p < SLOTS);
    chk("a_busy", a_busy, m_act);
    chk("a_done", a_done, m_act && m_p == SLOTS);
  endtask
  typedef struct {
    logic rst, start, dir, pause;
    logic [1:0] pat;
    logic valid, busy, done;
  } vec_t;
  vec_t tbl[22];
  initial begin
    int run, nv, dn, c4, idle;
    bit got;
    logic [5:0] prev;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 22; i++) begin
      rst = tbl[i].rst; b_start = tbl[i].start; b_dir = tbl[i].dir; b_pause = tbl[i].pause;
      tick();
      chk($sformatf("b_pattern[%0d]", i), b_pat, tbl[i].pat);
      chk($sformatf("b_valid[%0d]", i), b_valid, tbl[i].valid);
      chk($sformatf("b_busy[%0d]", i), b_busy, tbl[i].busy);
      chk($sformatf("b_done[%0d]", i), b_done, tbl[i].done);
    end
    rst = 0; b_start = 0; b_pause = 0;
    repeat (4) tick();
    c_start = 1;
    tick();
    c_start = 0;
    run = 0; nv = 0; got = 0; prev = '0;
    for (int k = 0; k < 7000 && !got; k++) begin
      if (k > 0) tick();
      if (c_valid) begin
        if (nv == 0) chk("c_first", c_pat, 63);
        else if (c_pat != prev) begin
          chk("c_hold", run, 100);
          chk("c_step", c_pat, prev - 6'd1);
          run = 0;
        end
        prev = c_pat; run++; nv++;
      end
      if (c_done) begin
        got = 1;
        chk("c_hold_last", run, 100);
        chk("c_last", prev, 0);
      end
    end
    chk("c_valid_cycles", nv, 6400);
    chk("c_done_seen", got, 1);
    tick();
    chk("c_busy_after", c_busy, 0);
    chk("c_done_after", c_done, 0);
    a_start = 1; a_dir = 0; a_gs = 0;
    tick();
    a_start = 0;
    c4 = (a_valid && a_pat == 3'd4) ? 1 : 0; dn = 0;
    for (int k = 0; k < 60; k++) begin
      a_pause = (c4 >= 1 && c4 <= 5);
      tick();
      if (a_valid && a_pat == 3'd4) c4++;
      dn += int'(a_done);
    end
    a_pause = 0;
    chk("a_pause_hold4", c4, 7);
    chk("a_pause_done_count", dn, 1);
    a_start = 1;
    tick();
    a_start = 0;
    repeat (5) tick();
    rst = 1;
    tick();
    chk("a_rst_pattern", a_pat, 0);
    chk("a_rst_valid", a_valid, 0);
    chk("a_rst_busy", a_busy, 0);
    rst = 0; dn = 0;
    repeat (20) begin
      tick();
      dn += int'(a_done);
    end
    chk("a_rst_no_done", dn, 0);
    a_start = 1;
    tick();
    a_start = 0;
    chk("a_restart_pattern", a_pat, 0);
    chk("a_restart_valid", a_valid, 1);
    repeat (20) tick();
    a_start = 1; a_dir = 1; dn = 0; idle = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      dn += int'(a_done);
      idle += int'(!a_busy);
    end
    a_start = 0;
    chk("a_held_start_dones", dn, 2);
    chk("a_held_start_idles", idle, 2);
    repeat (20) tick();
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      a_start = ($urandom_range(0, 9) == 0);
      a_dir = 1'($urandom_range(0, 1));
      a_pause = ($urandom_range(0, 3) == 0);
`ifdef STIM_GRAY_EN
      a_gs = 1'($urandom_range(0, 1));
`else
      a_gs = 0;
`endif
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
